// File: rtl/scp_mem_pkg.sv
// scp_mem_pkg: shared memory-interface constants for the two-port memory arbiter.
package scp_mem_pkg;
  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  localparam int MAX_WAIT_DEF = 8;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: CPU-priority grant decision; MEM_ARB_STARVE_EN adds a DMA wait
// counter that forces a DMA grant once it reaches MAX_WAIT.
module mem_arb_pick
  import scp_mem_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  output logic cpu_gnt,
  output logic dma_gnt
);
  logic starve;
`ifdef MEM_ARB_STARVE_EN
  logic [7:0] wait_cnt;
  assign starve = wait_cnt == 8'(MAX_WAIT);
  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= '0;
    else if (dma_gnt) wait_cnt <= '0;
    else if (dma_req && !starve) wait_cnt <= wait_cnt + 8'd1;
  end
`else
  localparam int unused_max_wait = MAX_WAIT;
  logic unused_clk;
  assign unused_clk = clk;
  assign starve = 1'b0;
`endif
  assign dma_gnt = !rst && dma_req && (!cpu_req || starve);
  assign cpu_gnt = !rst && cpu_req && !dma_gnt;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU/DMA) memory arbiter with registered memory port and
// two-cycle read return; optional anti-starvation via MEM_ARB_STARVE_EN.
module mem_arbiter
  import scp_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_byte_enable,
  input  logic          cpu_write_enable,
  input  logic [DW-1:0] cpu_write_data,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_read_data,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_byte_enable,
  input  logic          dma_write_enable,
  input  logic [DW-1:0] dma_write_data,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_read_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_byte_enable,
  output logic          mem_write_enable,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_in_data,
  output logic          owner
);
  logic gnt, sel, sel_we, rv1, rv2, own1, own2;
  mem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .cpu_gnt(cpu_gnt),
    .dma_gnt(dma_gnt)
  );
  always_comb begin
    gnt = cpu_gnt || dma_gnt;
    sel = dma_gnt ? PORT_DMA : PORT_CPU;
    sel_we = dma_gnt ? dma_write_enable : cpu_write_enable;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      mem_write_data <= '0;
      mem_write_enable <= 1'b0;
      mem_byte_enable <= 1'b0;
      owner <= PORT_CPU;
      rv1 <= 1'b0;
      rv2 <= 1'b0;
      own1 <= PORT_CPU;
      own2 <= PORT_CPU;
    end else begin
      mem_write_enable <= gnt && sel_we;
      mem_byte_enable <= gnt && (dma_gnt ? dma_byte_enable : cpu_byte_enable);
      if (gnt) begin
        mem_addr <= dma_gnt ? dma_addr : cpu_addr;
        mem_write_data <= dma_gnt ? dma_write_data : cpu_write_data;
        owner <= sel;
      end
      rv1 <= gnt && !sel_we;
      own1 <= sel;
      rv2 <= rv1;
      own2 <= own1;
    end
  end
  assign cpu_rvalid = rv2 && own2 == PORT_CPU;
  assign dma_rvalid = rv2 && own2 == PORT_DMA;
  assign cpu_read_data = mem_in_data;
  assign dma_read_data = mem_in_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and a randomized run
// against a transaction-level model of mem_arbiter.
module tb_mem_arbiter;
  localparam int MW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, cpu_byte_enable = 1'b0, cpu_write_enable = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_write_data = '0;
  logic dma_req = 1'b0, dma_byte_enable = 1'b0, dma_write_enable = 1'b0;
  logic [15:0] dma_addr = '0, dma_write_data = '0;
  logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_byte_enable, mem_write_enable, owner;
  logic [15:0] cpu_read_data, dma_read_data, mem_addr, mem_write_data;
  logic [15:0] mem_in_data = '0;
  int total = 0, bad = 0;

  mem_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_byte_enable(cpu_byte_enable),
    .cpu_write_enable(cpu_write_enable), .cpu_write_data(cpu_write_data),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_read_data(cpu_read_data),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_byte_enable(dma_byte_enable),
    .dma_write_enable(dma_write_enable), .dma_write_data(dma_write_data),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_read_data(dma_read_data),
    .mem_addr(mem_addr), .mem_byte_enable(mem_byte_enable),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_in_data(mem_in_data), .owner(owner)
  );

  always #5 clk = ~clk;

  // big-endian byte lanes: odd byte address is the low byte of the word
  function automatic logic [15:0] merge(logic [15:0] old, logic [15:0] a, logic b, logic [15:0] wd);
    if (!b) return wd;
    return a[0] ? {old[15:8], wd[7:0]} : {wd[7:0], old[7:0]};
  endfunction

  logic [15:0] env_ram [0:1023];
  logic [15:0] shadow [0:1023];
  always @(posedge clk) begin
    if (mem_write_enable === 1'b1)
      env_ram[mem_addr[10:1]] = merge(env_ram[mem_addr[10:1]], mem_addr, mem_byte_enable, mem_write_data);
    mem_in_data <= env_ram[mem_addr[10:1]];
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic set_cpu(logic r, logic [15:0] a, logic b, logic w, logic [15:0] d);
    cpu_req = r; cpu_addr = a; cpu_byte_enable = b; cpu_write_enable = w; cpu_write_data = d;
  endtask

  task automatic set_dma(logic r, logic [15:0] a, logic b, logic w, logic [15:0] d);
    dma_req = r; dma_addr = a; dma_byte_enable = b; dma_write_enable = w; dma_write_data = d;
  endtask

  task automatic reset_dut;
    nxt; rst = 1'b1; set_cpu(0, 0, 0, 0, 0); set_dma(0, 0, 0, 0, 0);
    nxt; nxt; rst = 1'b0; #1;
  endtask

  typedef struct {logic r, c, d, cw, dw, ec, ed, eo, ewe;} vec_t;
  vec_t tbl [8];

  typedef struct {bit own; logic [15:0] d;} rd_t;
  rd_t due [int];
  bit cp, dp, cb, cw, db, dw, ec, ed, exp_we, exp_be, exp_own, starve, own, w, exp_cv, exp_dv;
  logic [15:0] ca, cd, da, dd, exp_addr, exp_wd, a;
  int wcnt, cg;

  initial begin
    for (int i = 0; i < 1024; i++) env_ram[i] = 16'(i * 3 + 7);
    env_ram[10'h080] = 16'hBEEF;
    env_ram[10'h100] = 16'h1234;

    // reset with a pending CPU request
    nxt; rst = 1'b1; set_cpu(1, 16'h1234, 0, 1, 16'h5555); #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    nxt; #1;
    chk("rst_cpu_gnt2", cpu_gnt, 0);
    chk("rst_mem_we", mem_write_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_owner", owner, 0);
    nxt; rst = 1'b0; set_cpu(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1; chk("rst_no_rvalid", {cpu_rvalid, dma_rvalid}, 0); nxt;
    end

    // table vectors: grants this cycle, owner/write strobe next cycle
    reset_dut;
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 0, 1, 0, 0, 1};
    tbl[2] = '{0, 0, 1, 0, 1, 0, 1, 1, 1};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[4] = '{0, 1, 1, 0, 1, 1, 0, 0, 0};
    tbl[5] = '{0, 0, 1, 0, 0, 0, 1, 1, 0};
    tbl[6] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{0, 1, 1, 1, 0, 1, 0, 0, 1};
    for (int i = 0; i <= 8; i++) begin
      nxt;
      if (i < 8) begin
        rst = tbl[i].r;
        set_cpu(tbl[i].c, 16'h0010, 0, tbl[i].cw, 16'h0A00 + 16'(i));
        set_dma(tbl[i].d, 16'h0020, 0, tbl[i].dw, 16'h0B00 + 16'(i));
      end else begin
        rst = 1'b0; set_cpu(0, 0, 0, 0, 0); set_dma(0, 0, 0, 0, 0);
      end
      #1;
      if (i < 8) begin
        chk($sformatf("tbl%0d_cpu_gnt", i), cpu_gnt, tbl[i].ec);
        chk($sformatf("tbl%0d_dma_gnt", i), dma_gnt, tbl[i].ed);
      end
      if (i > 0) begin
        chk($sformatf("tbl%0d_owner", i - 1), owner, tbl[i-1].eo);
        chk($sformatf("tbl%0d_mem_we", i - 1), mem_write_enable, tbl[i-1].ewe);
      end
    end

    // CPU read of 0x0100
    reset_dut;
    nxt; set_cpu(1, 16'h0100, 0, 0, 0); #1;
    chk("rd_gnt", cpu_gnt, 1);
    nxt; set_cpu(0, 0, 0, 0, 0); #1;
    chk("rd_mem_addr", mem_addr, 16'h0100);
    chk("rd_mem_we", mem_write_enable, 0);
    nxt; #1;
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_data", cpu_read_data, 16'hBEEF);
    chk("rd_dma_rvalid", dma_rvalid, 0);
    nxt; #1;
    chk("rd_rvalid_once", cpu_rvalid, 0);

    // contention
    reset_dut;
    cg = 0;
`ifdef MEM_ARB_STARVE_EN
    for (int i = 0; i < 15; i++) begin
      nxt; set_cpu(1, 16'h0010, 0, 0, 0); set_dma(1, 16'h0020, 0, 0, 0); #1;
      chk($sformatf("starve%0d_dma_gnt", i), dma_gnt, (i % 5) == 4);
      chk($sformatf("starve%0d_cpu_gnt", i), cpu_gnt, (i % 5) != 4);
    end
`else
    for (int i = 0; i < 20; i++) begin
      nxt; set_cpu(1, 16'h0010, 0, 0, 0); set_dma(1, 16'h0020, 0, 0, 0); #1;
      if (cpu_gnt) cg++;
      chk($sformatf("cont%0d_dma_gnt", i), dma_gnt, 0);
    end
    chk("cont_cpu_grants", cg, 20);
`endif
    nxt; set_cpu(0, 0, 0, 0, 0); #1;
    chk("cont_dma_after_drop", dma_gnt, 1);
    nxt; set_dma(0, 0, 0, 0, 0);

    // interleaved DMA byte write then CPU word read
    reset_dut;
    nxt; set_dma(1, 16'h0201, 1, 1, 16'h00AA); #1;
    chk("il_dma_gnt", dma_gnt, 1);
    nxt; set_dma(0, 0, 0, 0, 0); set_cpu(1, 16'h0200, 0, 0, 0); #1;
    chk("il_owner", owner, 1);
    chk("il_mem_we", mem_write_enable, 1);
    chk("il_mem_be", mem_byte_enable, 1);
    chk("il_mem_addr", mem_addr, 16'h0201);
    chk("il_cpu_gnt", cpu_gnt, 1);
    nxt; set_cpu(0, 0, 0, 0, 0); #1;
    chk("il_owner_cpu", owner, 0);
    nxt; #1;
    chk("il_cpu_rvalid", cpu_rvalid, 1);
    chk("il_low_byte", cpu_read_data[7:0], 8'hAA);
    chk("il_dma_rvalid", dma_rvalid, 0);

    // reset in the cycle after a read grant
    reset_dut;
    nxt; set_cpu(1, 16'h0100, 0, 0, 0); #1;
    chk("mr_gnt", cpu_gnt, 1);
    nxt; rst = 1'b1; #1;
    chk("mr_gnt_in_rst", cpu_gnt, 0);
    nxt; rst = 1'b0; set_cpu(0, 0, 0, 0, 0); #1;
    chk("mr_no_rvalid", cpu_rvalid, 0);
    nxt; #1;
    chk("mr_no_rvalid2", cpu_rvalid, 0);

    // randomized traffic against the transaction model
    reset_dut;
    for (int i = 0; i < 1024; i++) shadow[i] = env_ram[i];
    exp_addr = '0; exp_wd = '0; exp_we = 0; exp_be = 0; exp_own = 0;
    wcnt = 0; cp = 0; dp = 0; due.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      nxt;
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1; ca = 16'($urandom); cb = 1'($urandom); cw = 1'($urandom); cd = 16'($urandom);
      end
      if (!dp && $urandom_range(0, 1) != 0) begin
        dp = 1; da = 16'($urandom); db = 1'($urandom); dw = 1'($urandom); dd = 16'($urandom);
      end
      set_cpu(cp, ca, cb, cw, cd);
      set_dma(dp, da, db, dw, dd);
      #1;
`ifdef MEM_ARB_STARVE_EN
      starve = (wcnt == MW);
`else
      starve = 0;
`endif
      ed = dp && (!cp || starve);
      ec = cp && !ed;
      exp_cv = due.exists(cyc) && !due[cyc].own;
      exp_dv = due.exists(cyc) && due[cyc].own;
      chk("r_cpu_gnt", cpu_gnt, ec);
      chk("r_dma_gnt", dma_gnt, ed);
      chk("r_mem_addr", mem_addr, exp_addr);
      chk("r_mem_wd", mem_write_data, exp_wd);
      chk("r_mem_we", mem_write_enable, exp_we);
      chk("r_mem_be", mem_byte_enable, exp_be);
      chk("r_owner", owner, exp_own);
      chk("r_cpu_rvalid", cpu_rvalid, exp_cv);
      chk("r_dma_rvalid", dma_rvalid, exp_dv);
      if (exp_cv) chk("r_cpu_data", cpu_read_data, due[cyc].d);
      if (exp_dv) chk("r_dma_data", dma_read_data, due[cyc].d);
      if (due.exists(cyc)) due.delete(cyc);
      if (ec || ed) begin
        own = ed;
        a = ed ? da : ca;
        w = ed ? dw : cw;
        exp_addr = a; exp_we = w; exp_be = ed ? db : cb; exp_wd = ed ? dd : cd; exp_own = own;
        if (w) shadow[a[10:1]] = merge(shadow[a[10:1]], a, exp_be, exp_wd);
        else due[cyc + 2] = '{own, shadow[a[10:1]]};
      end else begin
        exp_we = 0; exp_be = 0;
      end
`ifdef MEM_ARB_STARVE_EN
      if (ed) wcnt = 0;
      else if (dp && wcnt < MW) wcnt++;
`endif
      if (ec) cp = 0;
      if (ed) dp = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
